// File: rtl/fc_mac_array.sv
// Fully-connected layer MAC array: one shared input node is multiplied by NUM_LANES weights
// per beat, and the products are accumulated in a two-stage pipeline. Optional macro FC_MAC_ARRAY_RELU_EN clamps negative lane outputs to zero.
module fc_mac_array #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int NUM_LANES     = 4,
  parameter int ACC_WIDTH     = 32,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               run_i,
  input  logic [CNT_WIDTH-1:0]               num_inputs_i,
  input  logic                               valid_i,
  input  logic [IN_DATA_WIDTH-1:0]           node_i,
  input  logic [NUM_LANES*IN_DATA_WIDTH-1:0] weight_i,
  output logic                               ready_o,
  output logic                               busy_o,
  output logic                               valid_o,
  output logic [NUM_LANES*ACC_WIDTH-1:0]     result_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                      state;
  state_t                      state_next;
  logic [CNT_WIDTH-1:0]        remaining;
  logic                        prod_valid;
  logic                        start;
  logic                        accept;
  logic                        last_beat;
  logic signed [IN_DATA_WIDTH-1:0] node_s;

  assign node_s = node_i;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Outputs are gated by reset_n so they read 0 for the whole reset cycle,
  // not just after the edge that returns the FSM to IDLE.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    accept     = 1'b0;
    last_beat  = 1'b0;
    ready_o    = 1'b0;
    busy_o     = 1'b0;
    valid_o    = 1'b0;
    case (state)
      IDLE: begin
        start = run_i;
        if (run_i) state_next = (num_inputs_i == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        ready_o   = reset_n;
        busy_o    = reset_n;
        accept    = valid_i;
        last_beat = valid_i && (remaining == CNT_WIDTH'(1));
        if (last_beat) state_next = DRAIN;
      end
      DRAIN: begin
        busy_o     = reset_n;
        state_next = DONE;
      end
      DONE: begin
        busy_o     = reset_n;
        valid_o    = reset_n;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      remaining  <= '0;
      prod_valid <= 1'b0;
    end else begin
      prod_valid <= accept;
      if (start)       remaining <= num_inputs_i;
      else if (accept) remaining <= remaining - 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic signed [IN_DATA_WIDTH-1:0]   weight;
    logic signed [2*IN_DATA_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]       prod;
    logic signed [ACC_WIDTH-1:0]       acc;

    assign weight  = weight_i[k*IN_DATA_WIDTH +: IN_DATA_WIDTH];
    assign product = node_s * weight;

    // Stage 1 registers the sign-extended product; stage 2 folds it into the lane sum.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        prod <= '0;
        acc  <= '0;
      end else begin
        if (accept) prod <= ACC_WIDTH'(product);
        if (start)           acc <= '0;
        else if (prod_valid) acc <= acc + prod;
      end
    end

`ifdef FC_MAC_ARRAY_RELU_EN
    assign result_o[k*ACC_WIDTH +: ACC_WIDTH] = (!reset_n || acc[ACC_WIDTH-1]) ? '0 : acc;
`else
    assign result_o[k*ACC_WIDTH +: ACC_WIDTH] = !reset_n ? '0 : acc;
`endif
  end

endmodule
